tx_scheduler: RTL

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_sched_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/tx_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared state encoding, defaults and arbitration helper for tx_scheduler
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 200000;
  localparam int DEF_CNT_W          = 18;

  // last = index granted most recently; on contention the other one wins
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return last ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with last-grant pointer
module rr_arb2
  import tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  assign gnt = rr_pick(req, last);

  // pointer starts at 1 so requester 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - two-source byte scheduler with ack wait and inter-byte gap; TX_TIMEOUT_EN adds ack timeout
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] din0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] din1,
  output logic       gnt1,
  input  logic       rcv,
  output logic [7:0] data,
  output logic       datavalid,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LOAD  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam state_t ACK_EXIT = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       data_nx;
  logic             dv_nx;
  logic [1:0]       gnt_nx;
  logic [1:0]       arb_gnt;
  logic             advance;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (advance),
    .gnt     (arb_gnt)
  );

`ifdef TX_TIMEOUT_EN
  logic to_nx;
  logic timeout_q;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data;
    dv_nx    = 1'b0;
    gnt_nx   = 2'b00;
    advance  = 1'b0;
`ifdef TX_TIMEOUT_EN
    to_nx    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_nx = SEND;
          advance  = 1'b1;
          gnt_nx   = arb_gnt;
          dv_nx    = 1'b1;
          data_nx  = arb_gnt[1] ? din1 : din0;
        end
      end
      SEND: begin
        // counter is only consulted in WAIT_ACK when the timeout is built in
        state_nx = WAIT_ACK;
        cnt_nx   = TO_LOAD;
      end
      WAIT_ACK: begin
        if (rcv) begin
          state_nx = ACK_EXIT;
          cnt_nx   = GAP_LOAD;
        end
`ifdef TX_TIMEOUT_EN
        else if (cnt == '0) begin
          state_nx = ACK_EXIT;
          cnt_nx   = GAP_LOAD;
          to_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
`endif
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= 8'h00;
      datavalid <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      data      <= data_nx;
      datavalid <= dv_nx;
      gnt0      <= gnt_nx[0];
      gnt1      <= gnt_nx[1];
    end
  end

  assign busy = (state != IDLE);

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_nx;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
